pipeline_wb_buf: RTL
====================

PIPELINE_WB_BUF -- requirements
Module: pipeline_wb_buf

Interface
REQ-001 Parameter DATA_W, default 16, width of result, memory and writeback data.
REQ-002 Parameter REG_N, default 8, register count; RN_W = clog2(REG_N), minimum 1.
REQ-003 Parameter LD_OPC, default 3'b011, opcode value that selects memory data for writeback.
REQ-004 Parameter CNT_W, default 16, width of the retire counter.
REQ-005 clk input 1: single clock; all state updates on its rising edge.
REQ-006 rst input 1: asynchronous, active-high reset.
REQ-007 in_valid input 1 / in_ready output 1: upstream handshake; a beat is accepted when both are high at a rising edge.
REQ-008 in_opcode input 3: instruction opcode.
REQ-009 in_wr_en input 1 / in_wr_num input RN_W: register write enable and destination.
REQ-010 in_result input DATA_W: ALU result for non-load instructions.
REQ-011 in_ld_mode input 2: load extraction mode: 00 word, 01 low byte zero-extended, 10 low byte sign-extended, 11 high byte zero-extended.
REQ-012 rdata_in input DATA_W: synchronous-RAM read data, valid only in the cycle after a load beat is accepted, unregistered.
REQ-013 out_valid output 1 / out_ready input 1: downstream register-file port handshake.
REQ-014 writeback_data_out output DATA_W, writenum_out output RN_W: head entry data and destination.
REQ-015 write_out output 1: register-file write strobe = out_valid & out_ready & head wr_en.
REQ-016 fwd_valid output 1, fwd_num output RN_W, fwd_data output DATA_W: head entry exposed to hazard unit; fwd_valid = out_valid & head wr_en.
REQ-017 retire_cnt output CNT_W: count of completed output transfers.

Function
REQ-018 Storage: 2-entry FIFO; each entry holds opcode-derived is_ld, wr_en, wr_num, ld_mode, data, ld_pend flag.
REQ-019 in_ready = (occupancy < 2), from registered state only; no combinational path from out_ready to in_ready.
REQ-020 Latency: an accepted beat is at the head with out_valid=1 in the next cycle when the FIFO was empty.
REQ-021 On accept: is_ld = (in_opcode == LD_OPC); non-load stores in_result as data, ld_pend=0; load stores ld_pend=1.
REQ-022 Cycle after a load accept: rdata_in passes through ld_mode extraction, is written into that entry's data field, and ld_pend clears, whether or not the entry is at the head or is stalled.
REQ-023 Head data mux: if head ld_pend=1, writeback_data_out = extract(rdata_in); otherwise stored data.
REQ-024 Extraction: mode 01 = {zeros, rdata[7:0]}; 10 = {DATA_W-8 copies of rdata[7], rdata[7:0]}; 11 = {zeros, rdata[15:8]}; 00 = rdata unchanged.
REQ-025 Pop on out_valid & out_ready; wr_en=0 entries still pop and count but assert no write_out.
REQ-026 Occupancy: push only increments, pop only decrements, push and pop together hold; push at occupancy 2 cannot occur (in_ready=0).
REQ-027 Entries leave in acceptance order; no reordering or bypass between entries.
REQ-028 retire_cnt increments by 1 per pop, wrapping from 2^CNT_W-1 to 0.
REQ-029 out_valid = (occupancy > 0); outputs other than valid hold the head entry while stalled, including captured load data.

Reset
REQ-030 rst asserted: occupancy 0, all entries invalid, ld_pend cleared, retire_cnt 0; out_valid, write_out, fwd_valid 0 and in_ready 1 immediately, independent of clk.
REQ-031 Mid-operation reset discards pending entries; rdata_in in the first cycle after rst deasserts is ignored.
REQ-032 writeback_data_out, writenum_out, fwd_num, fwd_data read 0 while occupancy is 0.

Verification
REQ-033 ALU pass: accept opcode 000, wr_en=1, num 5, result 16'h1234, out_ready=1 -> next cycle write_out=1, writenum_out=5, data 16'h1234, retire_cnt 1.
REQ-034 Load word: accept opcode 011, num 2; next cycle rdata_in=16'hBEEF -> same cycle write_out=1, data 16'hBEEF.
REQ-035 Load stalled: opcode 011, mode 10, out_ready=0; next cycle rdata_in=16'h0080, then rdata_in=16'h0000 and out_ready=1 two cycles later -> data 16'hFF80 held throughout, one write.
REQ-036 Backpressure: out_ready=0, three beats offered back-to-back -> in_ready drops after 2 accepts; releasing out_ready drains both in order, third accepted only after a pop.
REQ-037 Reset mid-flight: 2 entries queued, rst pulsed between edges -> out_valid 0 and in_ready 1 immediately, retire_cnt 0, no write_out after release.
REQ-038 Counter wrap (CNT_W=4): 17 transfers -> retire_cnt reads 1; wr_en=0 beat -> pops with write_out 0, fwd_valid 0.

Source files
------------

// File: rtl/pipeline_wb_buf.sv
// Two-entry writeback buffer between the memory stage and the register file.
// Load entries capture synchronous-RAM data the cycle after acceptance.
module pipeline_wb_buf #(
  parameter int         DATA_W = 16,
  parameter int         REG_N  = 8,
  parameter logic [2:0] LD_OPC = 3'b011,
  parameter int         CNT_W  = 16,
  localparam int        RN_W   = (REG_N > 1) ? $clog2(REG_N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic              in_wr_en,
  input  logic [RN_W-1:0]   in_wr_num,
  input  logic [DATA_W-1:0] in_result,
  input  logic [1:0]        in_ld_mode,
  input  logic [DATA_W-1:0] rdata_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] writeback_data_out,
  output logic [RN_W-1:0]   writenum_out,
  output logic              write_out,
  output logic              fwd_valid,
  output logic [RN_W-1:0]   fwd_num,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] d,
                                                input logic [1:0]        m);
    case (m)
      2'b01:   extract = {{(DATA_W-8){1'b0}}, d[7:0]};
      2'b10:   extract = {{(DATA_W-8){d[7]}}, d[7:0]};
      2'b11:   extract = {{(DATA_W-8){1'b0}}, d[15:8]};
      default: extract = d;
    endcase
  endfunction

  logic [1:0]        count_r;
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic              ld_cap_r;
  logic              ld_idx_r;
  logic [CNT_W-1:0]  retire_cnt_r;

  logic              ent_is_ld_r   [2];
  logic              ent_wr_en_r   [2];
  logic [RN_W-1:0]   ent_wr_num_r  [2];
  logic [1:0]        ent_ld_mode_r [2];
  logic [DATA_W-1:0] ent_data_r    [2];
  logic              ent_ld_pend_r [2];

  logic              push_s;
  logic              pop_s;
  logic              is_ld_s;
  logic              has_head_s;
  logic              head_wr_en_s;
  logic [RN_W-1:0]   head_num_s;
  logic [DATA_W-1:0] head_data_s;

  assign has_head_s = (count_r != 2'd0);
  assign push_s     = in_valid & in_ready;
  assign pop_s      = has_head_s & out_ready;
  assign is_ld_s    = (in_opcode == LD_OPC);

  // Head selection; a load still awaiting RAM data forwards rdata_in directly.
  always_comb begin
    head_wr_en_s = 1'b0;
    head_num_s   = '0;
    head_data_s  = '0;
    if (has_head_s) begin
      head_wr_en_s = ent_wr_en_r[rd_ptr_r];
      head_num_s   = ent_wr_num_r[rd_ptr_r];
      if (ent_is_ld_r[rd_ptr_r] && ent_ld_pend_r[rd_ptr_r]) begin
        head_data_s = extract(rdata_in, ent_ld_mode_r[rd_ptr_r]);
      end else begin
        head_data_s = ent_data_r[rd_ptr_r];
      end
    end else begin
      head_wr_en_s = 1'b0;
    end
  end

  // FIFO storage, pointers, occupancy, load capture and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r      <= 2'd0;
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      ld_cap_r     <= 1'b0;
      ld_idx_r     <= 1'b0;
      retire_cnt_r <= '0;
      for (int i = 0; i < 2; i++) begin
        ent_is_ld_r[i]   <= 1'b0;
        ent_wr_en_r[i]   <= 1'b0;
        ent_wr_num_r[i]  <= '0;
        ent_ld_mode_r[i] <= 2'b00;
        ent_data_r[i]    <= '0;
        ent_ld_pend_r[i] <= 1'b0;
      end
    end else begin
      // The loaded slot was pushed last cycle, so it never collides with this cycle's push.
      if (ld_cap_r) begin
        ent_data_r[ld_idx_r]    <= extract(rdata_in, ent_ld_mode_r[ld_idx_r]);
        ent_ld_pend_r[ld_idx_r] <= 1'b0;
      end
      if (push_s) begin
        ent_is_ld_r[wr_ptr_r]   <= is_ld_s;
        ent_wr_en_r[wr_ptr_r]   <= in_wr_en;
        ent_wr_num_r[wr_ptr_r]  <= in_wr_num;
        ent_ld_mode_r[wr_ptr_r] <= in_ld_mode;
        ent_data_r[wr_ptr_r]    <= is_ld_s ? '0 : in_result;
        ent_ld_pend_r[wr_ptr_r] <= is_ld_s;
        wr_ptr_r                <= ~wr_ptr_r;
      end
      ld_cap_r <= push_s & is_ld_s;
      ld_idx_r <= wr_ptr_r;
      if (pop_s) begin
        rd_ptr_r     <= ~rd_ptr_r;
        retire_cnt_r <= retire_cnt_r + CNT_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign in_ready           = (count_r != 2'd2);
  assign out_valid          = has_head_s;
  assign writeback_data_out = head_data_s;
  assign writenum_out       = head_num_s;
  assign write_out          = pop_s & head_wr_en_s;
  assign fwd_valid          = has_head_s & head_wr_en_s;
  assign fwd_num            = head_num_s;
  assign fwd_data           = head_data_s;
  assign retire_cnt         = retire_cnt_r;

endmodule
